// File: rtl/csr_exec_pkg.sv
// Shared definitions for the execute-stage CSR sequencer: operation encodings,
// sequencer states and the read-only CSR address test.
package csr_exec_pkg;

  localparam int ZIMM_W = 5;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  // Takes the two top address bits; 2'b11 marks the read-only CSR space.
  function automatic logic is_ro_addr(input logic [1:0] addr_hi);
    return addr_hi == 2'b11;
  endfunction

endpackage

// File: rtl/csr_exec_alu.sv
// Combinational read-modify-write merge for CSRRW/CSRRS/CSRRC.
// The reserved op passes the old value through unchanged.
module csr_exec_alu
  import csr_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e         op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = src;
      CSR_OP_RS: new_val = old_val | src;
      CSR_OP_RC: new_val = old_val & ~src;
      default:   new_val = old_val;
    endcase
  end

endmodule

// File: rtl/csr_exec.sv
// Execute-stage CSR access sequencer: reads the CSR, merges the source operand,
// optionally writes back, and returns the old value for rd.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for a request; req_ready high unless flushed
//  ST_READ  | csr_addr driven, optional csr_rd, old/new values captured
//  ST_WRITE | csr_wr pulse with merged data
//  ST_RESP  | rsp_valid held until rsp_ready (or flush)
module csr_exec
  import csr_exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_use_imm,
  input  logic [REG_IDX_W-1:0]  req_rs1_idx,
  input  logic [ZIMM_W-1:0]     req_zimm,
  input  logic [XLEN-1:0]       req_rs1_data,
  input  logic [REG_IDX_W-1:0]  req_rd_idx,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic                  flush,
  output logic                  csr_rd,
  output logic                  csr_wr,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       csr_wdata,
  input  logic [XLEN-1:0]       csr_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_IDX_W-1:0]  rsp_rd_idx,
  output logic [XLEN-1:0]       rsp_rd_data,
  output logic                  rsp_illegal
);

  csr_state_e            state_q, state_d;
  csr_op_e               op_q;
  logic                  use_imm_q;
  logic [REG_IDX_W-1:0]  rs1_idx_q;
  logic [ZIMM_W-1:0]     zimm_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [REG_IDX_W-1:0]  rd_idx_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       new_q;
  logic [XLEN-1:0]       rsp_data_q;
  logic                  illegal_q;

  logic                  accept;
  logic                  read_en;
  logic                  do_write;
  logic                  illegal;
  logic [ZIMM_W-1:0]     src_idx;
  logic [XLEN-1:0]       src;
  logic [XLEN-1:0]       old_val;
  logic [XLEN-1:0]       new_val;

  assign accept   = req_valid & req_ready;
  assign src      = use_imm_q ? {{(XLEN-ZIMM_W){1'b0}}, zimm_q} : rs1_data_q;
  assign src_idx  = use_imm_q ? zimm_q : rs1_idx_q;
  // CSRRW to x0 must not read, so a read with side effects is never triggered.
  assign read_en  = !((op_q == CSR_OP_RW) && (rd_idx_q == '0));
  assign old_val  = read_en ? csr_rdata : '0;
  assign do_write = (op_q == CSR_OP_RW) || (src_idx != '0);
  assign illegal  = (op_q == CSR_OP_NONE) ||
                    (do_write && is_ro_addr(addr_q[CSR_ADDR_W-1 -: 2]));

  csr_exec_alu #(.XLEN(XLEN)) u_alu (
    .op      (op_q),
    .old_val (old_val),
    .src     (src),
    .new_val (new_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= CSR_OP_NONE;
      use_imm_q  <= 1'b0;
      rs1_idx_q  <= '0;
      zimm_q     <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      addr_q     <= '0;
      new_q      <= '0;
      rsp_data_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= csr_op_e'(req_op);
        use_imm_q  <= req_use_imm;
        rs1_idx_q  <= req_rs1_idx;
        zimm_q     <= req_zimm;
        rs1_data_q <= req_rs1_data;
        rd_idx_q   <= req_rd_idx;
        addr_q     <= req_addr;
      end
      if (state_q == ST_READ) begin
        new_q      <= new_val;
        rsp_data_q <= illegal ? '0 : old_val;
        illegal_q  <= illegal;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    csr_rd    = 1'b0;
    csr_wr    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) state_d = ST_READ;
      end
      ST_READ: begin
        csr_addr = addr_q;
        csr_rd   = read_en;
        if (flush)                     state_d = ST_IDLE;
        else if (do_write && !illegal) state_d = ST_WRITE;
        else                           state_d = ST_RESP;
      end
      ST_WRITE: begin
        // The write commits even under flush; only the response is dropped.
        csr_addr  = addr_q;
        csr_wr    = 1'b1;
        csr_wdata = new_q;
        state_d   = flush ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (flush || rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_rd_idx  = rd_idx_q;
  assign rsp_rd_data = rsp_data_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_exec.sv
// Self-checking bench for csr_exec: directed spec cases, flush/reset cases and
// randomized transactions checked against a plain CSR-array reference model.
module tb_csr_exec;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_use_imm;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_zimm;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd_idx;
  logic [11:0] req_addr;
  logic        flush;
  logic        csr_rd;
  logic        csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_rd_data;
  logic        rsp_illegal;

  int checks = 0;
  int failures = 0;

  // mem is the mcsr stand-in seen by the DUT; ref_mem is the expected CSR state.
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];

  assign csr_rdata = mem[csr_addr];

  csr_exec dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_use_imm  (req_use_imm),
    .req_rs1_idx  (req_rs1_idx),
    .req_zimm     (req_zimm),
    .req_rs1_data (req_rs1_data),
    .req_rd_idx   (req_rd_idx),
    .req_addr     (req_addr),
    .flush        (flush),
    .csr_rd       (csr_rd),
    .csr_wr       (csr_wr),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rd_idx   (rsp_rd_idx),
    .rsp_rd_data  (rsp_rd_data),
    .rsp_illegal  (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [11:0] addr, input logic [31:0] val);
    mem[addr]     = val;
    ref_mem[addr] = val;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic use_imm, input logic [4:0] rs1_idx,
                           input logic [4:0] zimm, input logic [31:0] rs1_data,
                           input logic [4:0] rd_idx, input logic [11:0] addr);
    req_op       = op;
    req_use_imm  = use_imm;
    req_rs1_idx  = rs1_idx;
    req_zimm     = zimm;
    req_rs1_data = rs1_data;
    req_rd_idx   = rd_idx;
    req_addr     = addr;
    req_valid    = 1'b1;
  endtask

  // One full transaction accepted with hold cycles of rsp_ready low once rsp_valid appears.
  task automatic txn(input logic [1:0] op, input logic use_imm, input logic [4:0] rs1_idx,
                     input logic [4:0] zimm, input logic [31:0] rs1_data,
                     input logic [4:0] rd_idx, input logic [11:0] addr, input int hold);
    logic        reads, do_wr, ill;
    logic [31:0] src, old_v, new_v, exp_data;
    int          exp_rd, exp_wr, exp_rsp;
    int          rd_c, wr_c, rsp_c, n_rd, n_wr, hold_left;
    bit          done;
    src      = use_imm ? {27'd0, zimm} : rs1_data;
    reads    = !(op == 2'b01 && rd_idx == 5'd0);
    old_v    = reads ? ref_mem[addr] : 32'd0;
    do_wr    = (op == 2'b01) || ((use_imm ? zimm : rs1_idx) != 5'd0);
    ill      = (op == 2'b00) || (do_wr && addr >= 12'hC00);
    case (op)
      2'b01:   new_v = src;
      2'b10:   new_v = old_v | src;
      2'b11:   new_v = old_v & ~src;
      default: new_v = old_v;
    endcase
    exp_data = ill ? 32'd0 : old_v;
    exp_rd   = reads ? 1 : -1;
    exp_wr   = (do_wr && !ill) ? 2 : -1;
    exp_rsp  = (do_wr && !ill) ? 3 : 2;
    if (exp_wr > 0) ref_mem[addr] = new_v;

    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    drive_req(op, use_imm, rs1_idx, zimm, rs1_data, rd_idx, addr);
    rsp_ready = (hold == 0);
    hold_left = hold;
    rd_c = -1; wr_c = -1; rsp_c = -1; n_rd = 0; n_wr = 0; done = 0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 12 && !done; c++) begin
      if (c > 1) @(negedge clk);
      check("rd_wr_exclusive", {31'd0, csr_rd & csr_wr}, 32'd0);
      if (csr_rd) begin
        n_rd++;
        if (rd_c < 0) rd_c = c;
        check("rd_addr", {20'd0, csr_addr}, {20'd0, addr});
      end
      if (csr_wr) begin
        n_wr++;
        if (wr_c < 0) wr_c = c;
        check("wr_addr", {20'd0, csr_addr}, {20'd0, addr});
        check("wr_data", csr_wdata, new_v);
        mem[csr_addr] = csr_wdata;
      end
      if (rsp_valid) begin
        if (rsp_c < 0) rsp_c = c;
        check("rsp_rd_idx", {27'd0, rsp_rd_idx}, {27'd0, rd_idx});
        check("rsp_rd_data", rsp_rd_data, exp_data);
        check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, ill});
        if (hold_left > 0) begin
          hold_left--;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
          done = 1;
        end
      end
    end
    check("rsp_seen", {31'd0, done}, 32'd1);
    check("rd_cycle", rd_c, exp_rd);
    check("rd_count", n_rd, reads ? 1 : 0);
    check("wr_cycle", wr_c, exp_wr);
    check("wr_count", n_wr, (exp_wr > 0) ? 1 : 0);
    check("rsp_cycle", rsp_c, exp_rsp);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  logic [11:0] addr_pool [7];

  initial begin
    addr_pool = '{12'h340, 12'h300, 12'h304, 12'h305, 12'hF14, 12'hC00, 12'h7C0};
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    req_op = 2'b00; req_use_imm = 1'b0; req_rs1_idx = 5'd0; req_zimm = 5'd0;
    req_rs1_data = 32'd0; req_rd_idx = 5'd0; req_addr = 12'd0;

    repeat (2) @(negedge clk);
    check("reset_csr_rd", {31'd0, csr_rd}, 32'd0);
    check("reset_csr_wr", {31'd0, csr_wr}, 32'd0);
    check("reset_csr_addr", {20'd0, csr_addr}, 32'd0);
    check("reset_csr_wdata", csr_wdata, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
    check("reset_rsp_rd_idx", {27'd0, rsp_rd_idx}, 32'd0);
    check("reset_rsp_rd_data", rsp_rd_data, 32'd0);
    rst = 1'b1;

    // Directed cases.
    preset(12'h340, 32'hAA);
    txn(2'b01, 1'b0, 5'd7, 5'd0, 32'h1234, 5'd5, 12'h340, 0);
    check("csrrw_mem", ref_mem[12'h340], 32'h1234);
    preset(12'h300, 32'h8);
    txn(2'b10, 1'b0, 5'd0, 5'd0, 32'hFFFF_FFFF, 5'd3, 12'h300, 0);
    preset(12'h304, 32'hF);
    txn(2'b11, 1'b1, 5'd9, 5'd3, 32'h0, 5'd4, 12'h304, 0);
    preset(12'h305, 32'h77);
    txn(2'b01, 1'b0, 5'd2, 5'd0, 32'h8000_0100, 5'd0, 12'h305, 0);
    preset(12'hF14, 32'h5);
    txn(2'b01, 1'b0, 5'd2, 5'd0, 32'hDEAD, 5'd6, 12'hF14, 0);
    txn(2'b00, 1'b0, 5'd1, 5'd0, 32'h1, 5'd8, 12'h340, 0);
    txn(2'b10, 1'b1, 5'd0, 5'd0, 32'h0, 5'd9, 12'hF14, 3);

    // Flush in READ: no write, no response.
    @(negedge clk);
    drive_req(2'b01, 1'b0, 5'd1, 5'd0, 32'h4242, 5'd1, 12'h340);
    @(negedge clk);
    req_valid = 1'b0;
    check("flush_read_rd", {31'd0, csr_rd}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_read_wr", {31'd0, csr_wr}, 32'd0);
    check("flush_read_rsp", {31'd0, rsp_valid}, 32'd0);
    check("flush_read_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("flush_read_rsp2", {31'd0, rsp_valid | csr_wr}, 32'd0);

    // Flush in WRITE: the write commits, the response is dropped.
    drive_req(2'b01, 1'b0, 5'd1, 5'd0, 32'h9999, 5'd1, 12'h341);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_write_wr", {31'd0, csr_wr}, 32'd1);
    check("flush_write_data", csr_wdata, 32'h9999);
    mem[csr_addr] = csr_wdata;
    ref_mem[12'h341] = 32'h9999;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_write_rsp", {31'd0, rsp_valid}, 32'd0);
    check("flush_write_ready", {31'd0, req_ready}, 32'd1);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    drive_req(2'b10, 1'b0, 5'd0, 5'd0, 32'h0, 5'd2, 12'h300);
    flush = 1'b1;
    #1;
    check("flush_idle_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_idle_no_rd", {31'd0, csr_rd}, 32'd0);
    check("flush_idle_ready2", {31'd0, req_ready}, 32'd1);

    // Flush in RESP drops the response.
    @(negedge clk);
    drive_req(2'b10, 1'b0, 5'd0, 5'd0, 32'h0, 5'd2, 12'h300);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_resp_valid", {31'd0, rsp_valid}, 32'd1);
    check("flush_resp_data", rsp_rd_data, ref_mem[12'h300]);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_resp_dropped", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted mid-WRITE clears outputs immediately.
    @(negedge clk);
    drive_req(2'b01, 1'b0, 5'd3, 5'd0, 32'h5555, 5'd1, 12'h342);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_wr", {31'd0, csr_wr}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_wr", {31'd0, csr_wr}, 32'd0);
    check("rst_rd", {31'd0, csr_rd}, 32'd0);
    check("rst_addr", {20'd0, csr_addr}, 32'd0);
    check("rst_wdata", csr_wdata, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized transactions.
    for (int i = 0; i < 7; i++) preset(addr_pool[i], $urandom);
    for (int n = 0; n < 40; n++) begin
      logic [4:0] ri, rz, rdi;
      ri  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rz  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rdi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      txn(2'($urandom), 1'($urandom), ri, rz, $urandom, rdi,
          addr_pool[$urandom_range(0, 6)], $urandom_range(0, 2));
    end
    for (int i = 0; i < 7; i++) check("final_mem", mem[addr_pool[i]], ref_mem[addr_pool[i]]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
